// File: rtl/pi_stream_launcher64_if.sv
// Bundle between the PI stream launcher, its host (sample/result banks) and the integrator.
// Latency: none, wires only.
// Backpressure: none; every transfer is a single-cycle strobe or pulse.
`ifndef N_WindTurbine
`define N_WindTurbine 4
`endif

interface pi_stream_launcher64_if #(
    parameter int N = `N_WindTurbine
);
    localparam int AW = $clog2(N);

    logic          step_sta;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic          done_sig;
    logic [63:0]   y;
    logic [AW-1:0] rd_addr;
    logic [63:0]   rd_data;
    logic          done_read_x;
    logic          sta;
    logic [63:0]   x;
    logic          busy;
    logic          step_done;
    logic          err_overrun;
    logic          err_timeout;

    // Host / integrator side
    modport master (
        output step_sta, wr_en, wr_addr, wr_data, done_sig, y, rd_addr,
        input  rd_data, done_read_x, sta, x, busy, step_done, err_overrun, err_timeout
    );

    // Launcher side
    modport slave (
        input  step_sta, wr_en, wr_addr, wr_data, done_sig, y, rd_addr,
        output rd_data, done_read_x, sta, x, busy, step_done, err_overrun, err_timeout
    );
endinterface

// File: rtl/pi_stream_launcher64.sv
// Sequences one step of the PI integrator: done_read_x pre-pulse, sta + N-word x burst, N-word y capture.
// Latency: done_read_x 1 cycle after step_sta, sta/word 0 LEAD cycles later; step_done N-1 cycles after done_sig.
// No backpressure: step_sta while busy is dropped (err_overrun); a missing done_sig ends the step (err_timeout).
`ifndef N_WindTurbine
`define N_WindTurbine 4
`endif

module pi_stream_launcher64 #(
    parameter int N       = `N_WindTurbine,
    parameter int LEAD    = 10,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    pi_stream_launcher64_if.slave io
);
    localparam int AW   = $clog2(N);
    localparam int CMAX = (LEAD > TIMEOUT) ? LEAD : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_STREAM,
        S_WAIT_DONE,
        S_CAPTURE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;           // lead countdown, then done_sig wait counter
    logic [AW-1:0] idx_q, idx_d;           // stream index k, then capture index
    logic          done_read_x_q, done_read_x_d;
    logic          err_overrun_q, err_overrun_d;
    logic          err_timeout_q, err_timeout_d;
    logic [63:0]   rd_data_q, rd_data_d;

    logic [63:0]   sample_bank [N];
    logic [63:0]   result_bank [N];

    logic          res_we;
    logic [AW-1:0] res_waddr;
    logic [63:0]   x_c;
    logic          sta_c;
    logic          step_done_c;

    // Next state, counters, bank write strobe and the combinational stream outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        done_read_x_d = 1'b0;
        err_overrun_d = err_overrun_q | (io.step_sta & (state_q != S_IDLE));
        err_timeout_d = err_timeout_q;
        rd_data_d     = result_bank[io.rd_addr];
        res_we        = 1'b0;
        res_waddr     = idx_q;
        x_c           = '0;
        sta_c         = 1'b0;
        step_done_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (io.step_sta) begin
                    state_d       = S_LEAD;
                    cnt_d         = CW'(LEAD - 1);
                    done_read_x_d = 1'b1;
                end
            end
            S_LEAD: begin
                if (cnt_q == '0) begin
                    state_d = S_STREAM;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STREAM: begin
                x_c   = sample_bank[idx_q];
                sta_c = (idx_q == '0);
                if (idx_q == IDX_LAST) begin
                    state_d = S_WAIT_DONE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            S_WAIT_DONE: begin
                // done_sig wins over the timeout; err_timeout rises exactly TIMEOUT
                // cycles after the last x word, together with the return to IDLE.
                if (io.done_sig) begin
                    res_we    = 1'b1;
                    res_waddr = '0;
                    idx_d     = AW'(1);
                    state_d   = S_CAPTURE;
                end else if (cnt_q == CW'(TIMEOUT - 2)) begin
                    err_timeout_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CAPTURE: begin
                res_we    = 1'b1;
                res_waddr = idx_q;
                if (idx_q == IDX_LAST) begin
                    step_done_c = 1'b1;
                    idx_d       = '0;
                    state_d     = S_IDLE;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered outputs; banks are deliberately left out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            done_read_x_q <= 1'b0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            done_read_x_q <= done_read_x_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Sample bank: a write in the cycle its word is streamed shows up next step
    always_ff @(posedge clk) begin
        if (io.wr_en) sample_bank[io.wr_addr] <= io.wr_data;
    end

    // Result bank: a read of the word being captured returns the previous value
    always_ff @(posedge clk) begin
        if (res_we) result_bank[res_waddr] <= io.y;
    end

    assign io.x           = x_c;
    assign io.sta         = sta_c;
    assign io.done_read_x = done_read_x_q;
    assign io.busy        = (state_q != S_IDLE);
    assign io.step_done   = step_done_c;
    assign io.err_overrun = err_overrun_q;
    assign io.err_timeout = err_timeout_q;
    assign io.rd_data     = rd_data_q;
endmodule

// File: tb/tb_pi_stream_launcher64.sv
// Bench for pi_stream_launcher64: directed + randomized steps checked against a cycle-offset model.
// Latency: integrator modelled as a 19-cycle delay line from sta/x to done_sig/y.
// Backpressure: none; step_sta is injected while busy to exercise overrun.
module tb_pi_stream_launcher64;
    localparam int N       = 4;
    localparam int LEAD    = 10;
    localparam int TIMEOUT = 20;
    localparam int DLY     = 19;
    localparam int AW      = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pi_stream_launcher64_if #(.N(N)) io ();

    pi_stream_launcher64 #(.N(N), .LEAD(LEAD), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    // Integrator stand-in: done_sig/y are sta/x delayed DLY cycles, gated by loop_en
    logic           loop_en;
    logic [DLY-1:0] dly_sta;
    logic [63:0]    dly_x [DLY];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_sta <= '0;
            for (int i = 0; i < DLY; i++) dly_x[i] <= '0;
        end else begin
            dly_sta  <= {dly_sta[DLY-2:0], io.sta};
            dly_x[0] <= io.x;
            for (int i = 1; i < DLY; i++) dly_x[i] <= dly_x[i-1];
        end
    end
    assign io.done_sig = loop_en & dly_sta[DLY-1];
    assign io.y        = dly_x[DLY-1];

    // Reference model state
    logic [63:0] m_bank [N];
    logic [63:0] m_res  [N];
    bit          m_ovr;
    bit          m_tmo;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [63:0] d);
        io.wr_en   = 1'b1;
        io.wr_addr = AW'(a);
        io.wr_data = d;
        tick();
        io.wr_en   = 1'b0;
        m_bank[a]  = d;
    endtask

    task automatic check_results();
        for (int i = 0; i < N; i++) begin
            io.rd_addr = AW'(i);
            tick();
            chk("rd_data", io.rd_data, m_res[i]);
        end
    endtask

    // One step started at offset 0; c is the cycle offset from step_sta.
    // loop: integrator answers; ovr_at: offset of an extra step_sta (-1 none);
    // ovr_done: extra step_sta in the step_done cycle; mid_k: bank write to
    // address mid_k in the cycle word mid_k is streamed (-1 none).
    task automatic run_step(input bit loop, input int ovr_at, input bit ovr_done,
                            input int mid_k, input logic [63:0] mid_val);
        int          t_sta;
        int          t_last;
        int          t_end;
        bit          pend_ovr;
        bit          pend_wr;
        logic [63:0] sent [N];
        t_sta    = 1 + LEAD;
        t_last   = LEAD + N;
        t_end    = loop ? (t_sta + DLY + N - 1) : (t_last + TIMEOUT - 1);
        pend_ovr = 1'b0;
        pend_wr  = 1'b0;
        loop_en  = loop;
        io.step_sta = 1'b1;
        tick();
        io.step_sta = 1'b0;
        for (int c = 1; c <= t_end + 2; c++) begin
            int k;
            k = c - t_sta;
            if (pend_ovr) begin
                m_ovr       = 1'b1;
                io.step_sta = 1'b0;
                pend_ovr    = 1'b0;
            end
            if (pend_wr) begin
                io.wr_en      = 1'b0;
                m_bank[mid_k] = mid_val;
                pend_wr       = 1'b0;
            end
            if (!loop && c == t_end + 1) m_tmo = 1'b1;
            chk("done_read_x", io.done_read_x, c == 1);
            chk("sta", io.sta, c == t_sta);
            if (k >= 0 && k < N) begin
                chk("x_word", io.x, m_bank[k]);
                sent[k] = m_bank[k];
            end else begin
                chk("x_idle", io.x, 64'd0);
            end
            chk("busy", io.busy, c <= t_end);
            chk("step_done", io.step_done, loop && c == t_end);
            chk("err_overrun", io.err_overrun, m_ovr);
            chk("err_timeout", io.err_timeout, m_tmo);
            if (c == ovr_at || (ovr_done && c == t_end)) begin
                io.step_sta = 1'b1;
                pend_ovr    = 1'b1;
            end
            if (mid_k >= 0 && k == mid_k) begin
                io.wr_en   = 1'b1;
                io.wr_addr = AW'(mid_k);
                io.wr_data = mid_val;
                pend_wr    = 1'b1;
            end
            tick();
        end
        if (loop) begin
            for (int i = 0; i < N; i++) m_res[i] = sent[i];
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int mk;
        io.step_sta = 1'b0;
        io.wr_en    = 1'b0;
        io.wr_addr  = '0;
        io.wr_data  = '0;
        io.rd_addr  = '0;
        loop_en     = 1'b0;
        m_ovr       = 1'b0;
        m_tmo       = 1'b0;
        for (int i = 0; i < N; i++) m_res[i] = '0;

        // Reset state
        #1;
        chk("rst_busy", io.busy, 1'b0);
        chk("rst_done_read_x", io.done_read_x, 1'b0);
        chk("rst_sta", io.sta, 1'b0);
        chk("rst_x", io.x, 64'd0);
        chk("rst_step_done", io.step_done, 1'b0);
        chk("rst_err_overrun", io.err_overrun, 1'b0);
        chk("rst_err_timeout", io.err_timeout, 1'b0);
        chk("rst_rd_data", io.rd_data, 64'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Directed step: 1.0 .. 4.0, overrun at offset 5 and in the step_done cycle
        wr(0, 64'h3FF0_0000_0000_0000);
        wr(1, 64'h4000_0000_0000_0000);
        wr(2, 64'h4008_0000_0000_0000);
        wr(3, 64'h4010_0000_0000_0000);
        run_step(1'b1, 5, 1'b1, -1, 64'd0);
        check_results();

        // Bank write in the cycle word 2 streams: old word now, new word next step
        run_step(1'b1, -1, 1'b0, 2, 64'hC000_0000_0000_0000);
        check_results();
        run_step(1'b1, -1, 1'b0, -1, 64'd0);
        check_results();

        // Integrator silent: timeout, no capture, then a normal step
        for (int i = 0; i < N; i++) wr(i, {$urandom, $urandom});
        run_step(1'b0, -1, 1'b0, -1, 64'd0);
        check_results();
        run_step(1'b1, -1, 1'b0, -1, 64'd0);
        check_results();

        // Randomized steps
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) wr(i, {$urandom, $urandom});
            mk = $urandom_range(0, N - 1);
            run_step(1'b1, $urandom_range(2, LEAD + N + DLY), 1'b0, mk, {$urandom, $urandom});
            check_results();
        end

        // Reset in the middle of STREAM (word 2 on x)
        loop_en     = 1'b1;
        io.step_sta = 1'b1;
        tick();
        io.step_sta = 1'b0;
        repeat (LEAD + 2) tick();
        chk("pre_rst_busy", io.busy, 1'b1);
        chk("pre_rst_x", io.x, m_bank[2]);
        #2 rst = 1'b1;
        #1;
        m_ovr = 1'b0;
        m_tmo = 1'b0;
        chk("mid_rst_busy", io.busy, 1'b0);
        chk("mid_rst_x", io.x, 64'd0);
        chk("mid_rst_sta", io.sta, 1'b0);
        chk("mid_rst_step_done", io.step_done, 1'b0);
        chk("mid_rst_err_overrun", io.err_overrun, m_ovr);
        chk("mid_rst_err_timeout", io.err_timeout, m_tmo);
        chk("mid_rst_rd_data", io.rd_data, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        run_step(1'b1, -1, 1'b0, -1, 64'd0);
        check_results();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
